// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED pattern generator:
//   - mode encodings for the 2-bit mode select
//   - bounce direction enum
//   - init_pattern(): LED value loaded when a new mode takes effect
// -----------------------------------------------------------------------------
package led_pkg;

    localparam logic [1:0] MODE_BLINK  = 2'd0;
    localparam logic [1:0] MODE_COUNT  = 2'd1;
    localparam logic [1:0] MODE_CHASE  = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Chase and bounce need a single lit LED to move around; the other modes
    // start dark. Callers size-cast the result to the bank width.
    function automatic logic [31:0] init_pattern(input logic [1:0] mode);
        if ((mode == MODE_CHASE) || (mode == MODE_BOUNCE)) begin
            return 32'd1;
        end
        return 32'd0;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a step indication every TICK_PERIOD = CLK_FREQ/TICK_HZ
// enabled cycles.
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   enable in   counter advances when high, holds when low
//   clear  in   synchronous restart of the period (counter back to 0)
//   step   out  high in the cycle whose closing edge ends a period; the
//               consumer acts on that same edge
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int TICK_HZ  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic step
);

    localparam int TICK_PERIOD = CLK_FREQ / TICK_HZ;
    localparam int CW          = $clog2(TICK_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(TICK_PERIOD - 1);

    logic [CW-1:0] count;
    logic          at_last;

    assign at_last = (count == LAST);
    // A clear on the wrap edge discards the step, so it is masked here too.
    assign step    = enable && at_last && !clear;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
// Steps an N-bit LED pattern at TICK_HZ in one of four modes: blink-all,
// binary count, one-hot chase, or bounce.
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   enable in   high = run, low = freeze pattern and prescaler
//   mode   in   0 BLINK, 1 COUNT, 2 CHASE, 3 BOUNCE
//   leds   out  registered LED pattern
//   tick   out  registered one-cycle pulse coincident with each step
// A change of mode restarts the period and reloads the pattern; that reload
// wins over a step landing on the same edge.
// -----------------------------------------------------------------------------
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int TICK_HZ  = 8,
    parameter int NUM_LEDS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic                tick
);

    logic [1:0]          mode_q;
    dir_t                dir;
    dir_t                dir_next;
    logic [NUM_LEDS-1:0] leds_next;
    logic                tick_next;
    logic                mode_change;
    logic                step;

    assign mode_change = (mode != mode_q);

    tick_prescaler #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .clear  (mode_change),
        .step   (step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_BLINK;
            leds   <= '0;
            tick   <= 1'b0;
            dir    <= DIR_UP;
        end else begin
            mode_q <= mode;
            leds   <= leds_next;
            tick   <= tick_next;
            dir    <= dir_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        leds_next = leds;
        dir_next  = dir;
        tick_next = 1'b0;

        if (mode_change) begin
            leds_next = NUM_LEDS'(init_pattern(mode));
            dir_next  = DIR_UP;
        end else if (step) begin
            tick_next = 1'b1;
            case (mode_q)
                MODE_BLINK: leds_next = ~leds;
                MODE_COUNT: leds_next = leds + NUM_LEDS'(1);
                MODE_CHASE: leds_next = {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]};
                default: begin
                    // Bounce: turn around as soon as the lit LED reaches an end.
                    if (dir == DIR_UP) begin
                        leds_next = {leds[NUM_LEDS-2:0], 1'b0};
                        if (leds[NUM_LEDS-2]) dir_next = DIR_DOWN;
                    end else begin
                        leds_next = {1'b0, leds[NUM_LEDS-1:1]};
                        if (leds[1]) dir_next = DIR_UP;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
// Directed bench for led_pattern_gen with CLK_FREQ=16, TICK_HZ=2, NUM_LEDS=4
// (step every 8 enabled cycles). Outputs are sampled 1 time unit after posedge.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int NL = 4;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode   = 2'd0;
    logic [NL-1:0] leds;
    logic          tick;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .CLK_FREQ (16),
        .TICK_HZ  (2),
        .NUM_LEDS (NL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .mode   (mode),
        .leds   (leds),
        .tick   (tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    // Seven quiet edges, then the step edge with the expected pattern.
    task automatic run_period(input string tag, input logic [NL-1:0] exp);
        repeat (7) tick_clk();
        check({tag, "_pre_tick"}, 32'(tick), 32'd0);
        tick_clk();
        check({tag, "_leds"}, 32'(leds), 32'(exp));
        check({tag, "_tick"}, 32'(tick), 32'd1);
    endtask

    // Safety net: the stimulus is fixed-length, this only catches a stuck sim.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NL-1:0] chase_exp  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [NL-1:0] bounce_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                          4'b0010, 4'b0001, 4'b0010};
        logic [NL-1:0] exp_leds;

        // 1. Reset state, then BLINK from release.
        enable = 1'b1;
        mode   = MODE_BLINK;
        repeat (3) tick_clk();
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick_clk();
            exp_leds = (e >= 8 && e < 16) ? 4'hF : 4'h0;
            check($sformatf("blink_leds_e%0d", e), 32'(leds), 32'(exp_leds));
            check($sformatf("blink_tick_e%0d", e), 32'(tick), 32'((e == 8) || (e == 16)));
        end

        // 2. COUNT held through reset; reload edge, then 16 steps with wrap.
        rst_n = 1'b0;
        mode  = MODE_COUNT;
        repeat (2) tick_clk();
        check("rst2_leds", 32'(leds), 32'd0);
        rst_n = 1'b1;
        tick_clk();
        check("count_reload_leds", 32'(leds), 32'd0);
        check("count_reload_tick", 32'(tick), 32'd0);
        for (int s = 1; s <= 16; s++) begin
            run_period($sformatf("count_s%0d", s), 4'(s));
        end

        // 3. CHASE.
        mode = MODE_CHASE;
        tick_clk();
        check("chase_reload_leds", 32'(leds), 32'd1);
        for (int s = 0; s < 4; s++) begin
            run_period($sformatf("chase_s%0d", s), chase_exp[s]);
        end

        // 4. BOUNCE, including both turnarounds.
        mode = MODE_BOUNCE;
        tick_clk();
        check("bounce_reload_leds", 32'(leds), 32'd1);
        for (int s = 0; s < 7; s++) begin
            run_period($sformatf("bounce_s%0d", s), bounce_exp[s]);
        end

        // 5. Freeze with the counter at 3; resume needs 5 more edges.
        repeat (3) tick_clk();
        enable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick_clk();
            if (tick !== 1'b0) check("freeze_tick", 32'(tick), 32'd0);
        end
        check("freeze_leds", 32'(leds), 32'b0010);
        check("freeze_tick_end", 32'(tick), 32'd0);
        enable = 1'b1;
        repeat (4) tick_clk();
        check("resume_early_tick", 32'(tick), 32'd0);
        check("resume_early_leds", 32'(leds), 32'b0010);
        tick_clk();
        check("resume_step_tick", 32'(tick), 32'd1);
        check("resume_step_leds", 32'(leds), 32'b0100);

        // 6. Mode change coinciding with a pending step, then reset mid-bounce.
        mode = MODE_COUNT;
        tick_clk();
        check("m6_count_reload", 32'(leds), 32'd0);
        repeat (7) tick_clk();
        check("m6_pending_leds", 32'(leds), 32'd0);
        mode = MODE_CHASE;
        tick_clk();
        check("m6_switch_leds", 32'(leds), 32'd1);
        check("m6_switch_tick", 32'(tick), 32'd0);
        run_period("m6_chase", 4'b0010);

        mode = MODE_BOUNCE;
        tick_clk();
        check("m6_bounce_reload", 32'(leds), 32'd1);
        run_period("m6_b1", 4'b0010);
        run_period("m6_b2", 4'b0100);
        run_period("m6_b3", 4'b1000);
        check("m6_dir_down", 32'(dut.dir), 32'(DIR_DOWN));
        repeat (3) tick_clk();
        rst_n = 1'b0;
        tick_clk();
        check("m6_rst_leds", 32'(leds), 32'd0);
        check("m6_rst_tick", 32'(tick), 32'd0);
        check("m6_rst_dir", 32'(dut.dir), 32'(DIR_UP));
        rst_n = 1'b1;
        tick_clk();
        check("m6_post_rst_reload", 32'(leds), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised successor to the single-LED blinker. A prescaler derives a step tick from the system clock, and each tick advances an N-bit LED pattern in one of four runtime-selectable modes: blink-all, binary count, chase, or bounce. It sits at board top level, drives the LED bank directly, and exports the step tick for other status logic.

Parameters:
CLK_FREQ, 25_000_000, system clock frequency in Hz
TICK_HZ, 8, pattern steps per second; TICK_PERIOD = CLK_FREQ/TICK_HZ cycles (integer division, must be >= 2)
NUM_LEDS, 8, LED bank width (must be >= 2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low; clock clk
enable  in  1  high = prescaler runs and pattern advances; low = freeze
mode  in  2  0 BLINK, 1 COUNT, 2 CHASE, 3 BOUNCE
leds  out  NUM_LEDS  registered LED pattern
tick  out  1  registered one-cycle pulse, coincident with each pattern step

Behaviour:
- Reset (rst_n low at posedge clk): counter=0, leds=0, tick=0, dir=UP, mode_q=0 (BLINK).
- Prescaler: counter width $clog2(TICK_PERIOD). When enable=1, counter increments each cycle. At counter==TICK_PERIOD-1, counter wraps to 0 and a step occurs on the same edge (leds update, tick=1 for that cycle). Otherwise tick=0.
- First step is at the TICK_PERIOD-th rising edge after rst_n goes high. Steps then repeat every TICK_PERIOD cycles.
- enable=0: counter, leds, and dir hold; tick=0. Counting resumes from the held counter value.
- Step action per mode_q:
  BLINK: leds <= ~leds (all bits toggle together).
  COUNT: leds <= leds+1, wrapping modulo 2^NUM_LEDS (all-ones -> 0).
  CHASE: one-hot rotate toward MSB; bit NUM_LEDS-1 wraps to bit 0.
  BOUNCE: two-state FSM in dir {UP, DOWN}.
    UP: shift left. When the new value has bit NUM_LEDS-1 set, dir <= DOWN.
    DOWN: shift right. When the new value has bit 0 set, dir <= UP.
- Mode change:
  - mode is registered into mode_q every cycle, regardless of enable.
  - When mode != mode_q at a posedge:
    - mode_q <= mode
    - counter <= 0
    - tick <= 0
    - dir <= UP
    - leds <= initial value of the new mode: BLINK 0, COUNT 0, CHASE 1, BOUNCE 1.
  - This takes priority over a coincident step: the step is discarded.
  - The first step in the new mode comes TICK_PERIOD enabled cycles later.
- Reset value is leds=0 with mode_q=BLINK. If mode≠0 while reset is held, the reload happens on the first edge after release. Only CHASE and BOUNCE change leds at that reload (to 1); BLINK and COUNT stay 0.
- Reset asserted mid-pattern: returns everything to reset values on that edge and overrides both mode change and step.
- CHASE/BOUNCE never see 0. The invariant holds because the mode reload always inserts 1.

Decomposition:
- Package led_pkg holds: mode encoding constants (MODE_BLINK=0, MODE_COUNT=1, MODE_CHASE=2, MODE_BOUNCE=3), the dir enum (UP=0, DOWN=1), and a function returning the initial pattern per mode.
- One sub-module, tick_prescaler (parameters CLK_FREQ, TICK_HZ; inputs clk, rst_n, enable, clear; output step).
- led_pattern_gen holds mode_q, the pattern register, and the bounce FSM.

Test Plan:
(All scenarios use CLK_FREQ=16, TICK_HZ=2, NUM_LEDS=4, so TICK_PERIOD=8.)
1. Reset release, mode=0, enable=1 -> leds=0000 until the 8th edge. Then 1111, then 0000 at the 16th edge. tick high exactly on those two cycles.
2. mode=1 held through reset, enable=1 -> leds=0000 after the reload edge. Steps give 0001, 0010, …, 1111, 0000 (wrap) every 8 cycles.
3. mode=2 -> leds=0001 after reload. Steps give 0010, 0100, 1000, 0001.
4. mode=3 -> 0001 → 0010 → 0100 → 1000 → 0100 → 0010 → 0001 → 0010. dir flips at 1000 and at 0001.
5. enable=0 for 20 cycles in the middle of a period (counter=3) -> leds and tick frozen. After re-enable, the next step comes 5 cycles later.
6. Change mode 1→2 on the same cycle as a pending step -> no count step. leds=0001 next cycle, and the next step comes 8 cycles later. Then assert rst_n=0 for one cycle mid-BOUNCE -> leds=0000, tick=0, dir=UP.
